// File: rtl/regfile_bulk_ctrl_if.sv
// Register-file port and dump-stream bundle between regfile_bulk_ctrl and its
// neighbours (register file write port, read port A, stream consumer).
interface regfile_bulk_ctrl_if #(
  parameter int Dwidth = 32,
  parameter int Awidth = 5
);
  logic              RF_WE;
  logic [Awidth-1:0] RF_WA;
  logic [Dwidth-1:0] RF_DataIn;
  logic              RF_RE_A;
  logic [Awidth-1:0] RF_RA_A;
  logic [Dwidth-1:0] RF_Out_A;
  logic              Dump_Valid;
  logic [Dwidth-1:0] Dump_Data;
  logic [Awidth-1:0] Dump_Addr;
  logic              Dump_Ready;

  modport master (
    output RF_WE, RF_WA, RF_DataIn, RF_RE_A, RF_RA_A,
    input  RF_Out_A,
    output Dump_Valid, Dump_Data, Dump_Addr,
    input  Dump_Ready
  );

  modport slave (
    input  RF_WE, RF_WA, RF_DataIn, RF_RE_A, RF_RA_A,
    output RF_Out_A,
    input  Dump_Valid, Dump_Data, Dump_Addr,
    output Dump_Ready
  );
endinterface

// File: rtl/regfile_bulk_ctrl.sv
// Bulk initiator for the register file: FILL writes a constant/incrementing
// pattern over an address range, DUMP streams a range out through read port A.
module regfile_bulk_ctrl #(
  parameter int Dwidth = 32,
  parameter int Awidth = 5
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Start,
  input  logic                Mode,
  input  logic [Awidth-1:0]   Base_Addr,
  input  logic [Awidth:0]     Count,
  input  logic [Dwidth-1:0]   Fill_Data,
  input  logic                Fill_Incr,
  output logic                Busy,
  output logic                Done,
  regfile_bulk_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_DUMP,
    S_FIN
  } state_t;

  localparam logic [Awidth:0] ONE = (Awidth+1)'(1);

  state_t            state_q, state_d;
  logic [Awidth-1:0] base_q, base_d;
  logic [Awidth:0]   count_q, count_d;
  logic [Dwidth-1:0] fill_q, fill_d;
  logic              incr_q, incr_d;
  logic [Awidth:0]   issue_q, issue_d;
  logic [Awidth:0]   acc_q, acc_d;

  logic              infl_q;
  logic [Awidth-1:0] infl_addr_q;
  logic [Dwidth-1:0] buf_data_q [2];
  logic [Awidth-1:0] buf_addr_q [2];
  logic              rd_ptr_q, wr_ptr_q;
  logic [1:0]        occ_q;

  logic [Awidth-1:0] cur_addr;
  logic [Dwidth-1:0] fill_word;
  logic              head_valid;
  logic              pop;
  logic              issue;
  logic [1:0]        committed;
  logic              fill_we;

  // Issue index doubles as the FILL word index and the DUMP read index.
  assign cur_addr   = base_q + issue_q[Awidth-1:0];
  assign fill_word  = fill_q + (incr_q ? Dwidth'(issue_q) : '0);
  assign head_valid = (state_q == S_DUMP) && (occ_q != 2'd0);
  assign pop        = head_valid && bus.Dump_Ready;
  // Words held or returning after this cycle's pop; a new read needs one free slot.
  assign committed  = occ_q + {1'b0, infl_q} - {1'b0, pop};
  assign issue      = (state_q == S_DUMP) && (issue_q != count_q) && (committed < 2'd2);
  assign fill_we    = (state_q == S_FILL);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    fill_d  = fill_q;
    incr_d  = incr_q;
    issue_d = issue_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          base_d  = Base_Addr;
          count_d = Count;
          fill_d  = Fill_Data;
          incr_d  = Fill_Incr;
          issue_d = '0;
          acc_d   = '0;
          if (Count == '0)  state_d = S_FIN;
          else if (Mode)    state_d = S_DUMP;
          else              state_d = S_FILL;
        end
      end
      S_FILL: begin
        issue_d = issue_q + ONE;
        if ((issue_q + ONE) == count_q) state_d = S_FIN;
      end
      S_DUMP: begin
        if (issue) issue_d = issue_q + ONE;
        if (pop) begin
          acc_d = acc_q + ONE;
          if ((acc_q + ONE) == count_q) state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      count_q     <= '0;
      fill_q      <= '0;
      incr_q      <= 1'b0;
      issue_q     <= '0;
      acc_q       <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      fill_q      <= fill_d;
      incr_q      <= incr_d;
      issue_q     <= issue_d;
      acc_q       <= acc_d;
      infl_q      <= issue;
      infl_addr_q <= cur_addr;
      if (infl_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop)    rd_ptr_q <= ~rd_ptr_q;
      occ_q       <= committed;
    end
  end

  // Read data is only meaningful the cycle after an issue; otherwise port A floats.
  always_ff @(posedge CLK) begin
    if (infl_q) begin
      buf_data_q[wr_ptr_q] <= bus.RF_Out_A;
      buf_addr_q[wr_ptr_q] <= infl_addr_q;
    end
  end

  assign Busy           = (state_q == S_FILL) || (state_q == S_DUMP);
  assign Done           = (state_q == S_FIN);
  assign bus.RF_WE      = fill_we;
  assign bus.RF_WA      = fill_we ? cur_addr  : '0;
  assign bus.RF_DataIn  = fill_we ? fill_word : '0;
  assign bus.RF_RE_A    = issue;
  assign bus.RF_RA_A    = issue ? cur_addr : '0;
  assign bus.Dump_Valid = head_valid;
  assign bus.Dump_Data  = head_valid ? buf_data_q[rd_ptr_q] : '0;
  assign bus.Dump_Addr  = head_valid ? buf_addr_q[rd_ptr_q] : '0;

  a_enables_exclusive: assert property (@(posedge CLK) disable iff (RST)
    !(bus.RF_WE && bus.RF_RE_A));
  a_buffer_bound: assert property (@(posedge CLK) disable iff (RST)
    (occ_q + {1'b0, infl_q}) <= 2'd2);

endmodule
